// File: rtl/sa_pkg.sv
// sa_pkg: shared defaults, FSM encoding and row-slicing helper for the systolic-array sequencer.
package sa_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DIM        = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FEED  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        FEED  = ST_FEED,
        DRAIN = ST_DRAIN
    } sa_state_e;

    // Bit offset of column col inside a packed row of width-bit elements.
    function automatic int col_lsb(input int col, input int width);
        return col * width;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line: DATA_WIDTH-bit delay line of DEPTH registers; DEPTH = 0 degenerates to a wire.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
    end else begin : g_reg
        logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_q;

        // NOTE: pipeline stages are flops, not memory, so they are reset; a stale
        // element left in flight would otherwise surface as a bogus result after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q[0] <= din;
                for (int k = 1; k < DEPTH; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/sa_ctrl.sv
// sa_ctrl: preloads B rows, streams skewed A rows and deskews C rows for a DIM x DIM systolic array.
// Define SA_CTRL_PERF_EN to add the sc_bubble_cnt output (FEED cycles without a valid A row).
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DIM        = DEF_DIM,
    parameter int ARRAY_LAT  = 1,
    parameter int CNT_W      = 8
) (
    input  logic                      sc_clk,
    input  logic                      sc_rst_n,
    input  logic                      sc_start,
    input  logic [CNT_W-1:0]          sc_n_rows,
    output logic                      sc_busy,
    output logic                      sc_done,
    input  logic [DIM*DATA_WIDTH-1:0] sc_w_data,
    input  logic                      sc_w_valid,
    output logic                      sc_w_ready,
    input  logic [DIM*DATA_WIDTH-1:0] sc_a_data,
    input  logic                      sc_a_valid,
    output logic                      sc_a_ready,
    output logic                      sc_sa_load,
    output logic [DIM*DATA_WIDTH-1:0] sc_sa_rd,
    output logic [DIM-1:0]            sc_sa_bd_pe,
    output logic [DIM*DATA_WIDTH-1:0] sc_sa_fdi,
    input  logic [DIM*DATA_WIDTH-1:0] sc_sa_gd,
    output logic [DIM*DATA_WIDTH-1:0] sc_res_data,
    output logic                      sc_res_valid
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]          sc_bubble_cnt
`endif
);

    localparam int ROW_W   = DIM * DATA_WIDTH;
    localparam int TAG_LEN = 2 * DIM - 1 + ARRAY_LAT;
    // Data path: row register + array + deskew reaches ARRAY_LAT+DIM; the tail stage pads to TAG_LEN.
    localparam int OUT_LAT = TAG_LEN - ARRAY_LAT - DIM;
    localparam int WCNT_W  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(DIM - 1);

    sa_state_e          state_q, state_d;
    logic [WCNT_W-1:0]  w_cnt_q;
    logic [CNT_W-1:0]   rows_left_q;
    logic [ROW_W-1:0]   row_q;
    logic [TAG_LEN-1:0] tag_sr_q;
    logic               w_hs, a_hs, start_acc;

    assign w_hs      = sc_w_valid & sc_w_ready;
    assign a_hs      = sc_a_valid & sc_a_ready;
    assign start_acc = (state_q == IDLE) & sc_start;

    assign sc_busy      = (state_q != IDLE);
    assign sc_sa_bd_pe  = DIM'(1);
    assign sc_res_valid = tag_sr_q[TAG_LEN-1];

    // NOTE: state and counters use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the simulator runs processes.
    always_ff @(posedge sc_clk or negedge sc_rst_n) begin
        if (!sc_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        sc_w_ready = 1'b0;
        sc_a_ready = 1'b0;
        sc_sa_load = 1'b0;
        sc_sa_rd   = '0;
        sc_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sc_start) state_d = LOAD;
            end
            LOAD: begin
                sc_w_ready = 1'b1;
                sc_sa_load = sc_w_valid;
                sc_sa_rd   = sc_w_data;
                if (sc_w_valid && (w_cnt_q == W_LAST)) state_d = FEED;
            end
            FEED: begin
                sc_a_ready = 1'b1;
                if (sc_a_valid && (rows_left_q == CNT_W'(1))) state_d = DRAIN;
            end
            DRAIN: begin
                if (tag_sr_q == '0) begin
                    sc_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sc_clk or negedge sc_rst_n) begin
        if (!sc_rst_n) begin
            w_cnt_q     <= '0;
            rows_left_q <= '0;
        end else begin
            if (w_hs) w_cnt_q <= (w_cnt_q == W_LAST) ? '0 : w_cnt_q + 1'b1;
            if (start_acc) begin
                rows_left_q <= (sc_n_rows == '0) ? CNT_W'(1) : sc_n_rows;
            end else if (a_hs) begin
                rows_left_q <= rows_left_q - 1'b1;
            end
        end
    end

    // Outside an accepted handshake a zero row with a cleared tag enters the pipe.
    always_ff @(posedge sc_clk or negedge sc_rst_n) begin
        if (!sc_rst_n) begin
            row_q    <= '0;
            tag_sr_q <= '0;
        end else begin
            row_q    <= a_hs ? sc_a_data : '0;
            tag_sr_q <= (tag_sr_q << 1) | TAG_LEN'(a_hs);
        end
    end

    for (genvar j = 0; j < DIM; j++) begin : g_col
        logic [DATA_WIDTH-1:0] deskewed;

        sa_skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(j)) u_skew (
            .clk   (sc_clk),
            .rst_n (sc_rst_n),
            .din   (row_q[col_lsb(j, DATA_WIDTH) +: DATA_WIDTH]),
            .dout  (sc_sa_fdi[col_lsb(j, DATA_WIDTH) +: DATA_WIDTH])
        );

        sa_skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DIM - 1 - j)) u_deskew (
            .clk   (sc_clk),
            .rst_n (sc_rst_n),
            .din   (sc_sa_gd[col_lsb(j, DATA_WIDTH) +: DATA_WIDTH]),
            .dout  (deskewed)
        );

        sa_skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(OUT_LAT)) u_out (
            .clk   (sc_clk),
            .rst_n (sc_rst_n),
            .din   (deskewed),
            .dout  (sc_res_data[col_lsb(j, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

`ifdef SA_CTRL_PERF_EN
    logic [CNT_W-1:0] bubble_cnt_q;

    always_ff @(posedge sc_clk or negedge sc_rst_n) begin
        if (!sc_rst_n) begin
            bubble_cnt_q <= '0;
        end else if (start_acc) begin
            bubble_cnt_q <= '0;
        end else if ((state_q == FEED) && !sc_a_valid && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign sc_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: directed jobs against a behavioural systolic-array model with a result scoreboard.
// Build with SA_CTRL_PERF_EN defined to also check sc_bubble_cnt.
module tb_sa_ctrl;

    localparam int DW    = 16;
    localparam int DIM   = 2;
    localparam int AL    = 1;
    localparam int CNT_W = 8;
    localparam int ROW_W = DIM * DW;
    localparam int LAT   = 1 + (DIM - 1) + AL + (DIM - 1);

    typedef logic [ROW_W-1:0] row_t;
    typedef struct {
        row_t data;
        int   cyc;
    } exp_t;

    logic             sc_clk, sc_rst_n, sc_start;
    logic [CNT_W-1:0] sc_n_rows;
    logic             sc_busy, sc_done;
    row_t             sc_w_data, sc_a_data, sc_sa_rd, sc_sa_fdi, sc_sa_gd, sc_res_data;
    logic             sc_w_valid, sc_w_ready, sc_a_valid, sc_a_ready, sc_sa_load, sc_res_valid;
    logic [DIM-1:0]   sc_sa_bd_pe;
`ifdef SA_CTRL_PERF_EN
    logic [CNT_W-1:0] sc_bubble_cnt;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    int   cyc = 0, done_cnt = 0, res_cnt = 0, load_cnt = 0, last_res_cyc = 0, done_cyc = 0;
    logic obs_w_hs, obs_a_hs, obs_load;
    row_t fh[4];
    row_t wt[DIM];
    int   ld_idx = 0;
    int   b_mat[DIM][DIM];
    int   a_mat[8][DIM];

    sa_ctrl #(.DATA_WIDTH(DW), .DIM(DIM), .ARRAY_LAT(AL), .CNT_W(CNT_W)) dut (
        .sc_clk       (sc_clk),
        .sc_rst_n     (sc_rst_n),
        .sc_start     (sc_start),
        .sc_n_rows    (sc_n_rows),
        .sc_busy      (sc_busy),
        .sc_done      (sc_done),
        .sc_w_data    (sc_w_data),
        .sc_w_valid   (sc_w_valid),
        .sc_w_ready   (sc_w_ready),
        .sc_a_data    (sc_a_data),
        .sc_a_valid   (sc_a_valid),
        .sc_a_ready   (sc_a_ready),
        .sc_sa_load   (sc_sa_load),
        .sc_sa_rd     (sc_sa_rd),
        .sc_sa_bd_pe  (sc_sa_bd_pe),
        .sc_sa_fdi    (sc_sa_fdi),
        .sc_sa_gd     (sc_sa_gd),
        .sc_res_data  (sc_res_data),
        .sc_res_valid (sc_res_valid)
`ifdef SA_CTRL_PERF_EN
        ,
        .sc_bubble_cnt(sc_bubble_cnt)
`endif
    );

    initial sc_clk = 1'b0;
    always #5 sc_clk = ~sc_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic row_t pack_row(input int v[DIM]);
        row_t r;
        r = '0;
        for (int j = 0; j < DIM; j++) r[j*DW +: DW] = DW'(v[j]);
        return r;
    endfunction

    // Reference C row: C[j] = sum_k A[k] * B[k][j], truncated to DW bits.
    function automatic row_t golden(input row_t a);
        row_t        r;
        logic [31:0] acc;
        r = '0;
        for (int j = 0; j < DIM; j++) begin
            acc = '0;
            for (int k = 0; k < DIM; k++) acc = acc + 32'(a[k*DW +: DW]) * 32'(b_mat[k][j]);
            r[j*DW +: DW] = acc[DW-1:0];
        end
        return r;
    endfunction

    // One clock cycle: observe at negedge, run scoreboard and array model, return at posedge+1.
    task automatic tick();
        exp_t        e;
        row_t        gd;
        logic [31:0] acc;
        @(negedge sc_clk);
        obs_w_hs = sc_w_valid & sc_w_ready;
        obs_a_hs = sc_a_valid & sc_a_ready;
        obs_load = sc_sa_load;
        if (sc_res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_res_valid", 64'(sc_res_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("res_data", 64'(sc_res_data), 64'(e.data));
                check("res_latency", 64'(cyc - e.cyc), 64'(LAT));
                res_cnt++;
                last_res_cyc = cyc;
            end
        end
        if (sc_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (sc_sa_load === 1'b1) load_cnt++;
        if (obs_a_hs === 1'b1) begin
            e.data = golden(sc_a_data);
            e.cyc  = cyc;
            sb.push_back(e);
        end
        if (!sc_rst_n) begin
            for (int h = 0; h < 4; h++) fh[h] = '0;
            for (int k = 0; k < DIM; k++) wt[k] = '0;
            ld_idx   = 0;
            sc_sa_gd = '0;
        end else begin
            for (int h = 3; h > 0; h--) fh[h] = fh[h-1];
            fh[0] = sc_sa_fdi;
            if (sc_sa_load === 1'b1) begin
                wt[ld_idx] = sc_sa_rd;
                ld_idx     = (ld_idx + 1) % DIM;
            end
            gd = '0;
            for (int j = 0; j < DIM; j++) begin
                acc = '0;
                for (int k = 0; k < DIM; k++)
                    acc = acc + 32'(fh[AL+j-k][k*DW +: DW]) * 32'(wt[k][j*DW +: DW]);
                gd[j*DW +: DW] = acc[DW-1:0];
            end
            sc_sa_gd = gd;
        end
        cyc++;
        @(posedge sc_clk);
        #1;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, ":busy"},      64'(sc_busy),      64'(0));
        check({p, ":done"},      64'(sc_done),      64'(0));
        check({p, ":w_ready"},   64'(sc_w_ready),   64'(0));
        check({p, ":a_ready"},   64'(sc_a_ready),   64'(0));
        check({p, ":load"},      64'(sc_sa_load),   64'(0));
        check({p, ":rd"},        64'(sc_sa_rd),     64'(0));
        check({p, ":fdi"},       64'(sc_sa_fdi),    64'(0));
        check({p, ":res_valid"}, 64'(sc_res_valid), 64'(0));
        check({p, ":res_data"},  64'(sc_res_data),  64'(0));
        check({p, ":bd_pe"},     64'(sc_sa_bd_pe),  64'(1));
    endtask

    task automatic start_job(input int n);
        sc_n_rows = CNT_W'(n);
        sc_start  = 1'b1;
        tick();
        sc_start  = 1'b0;
    endtask

    task automatic load_weights(input int w_gap, input string name);
        int guard;
        for (int k = 0; k < DIM; k++) begin
            if (k > 0) begin
                for (int g = 0; g < w_gap; g++) begin
                    sc_w_valid = 1'b0;
                    tick();
                    check({name, ":load_low_in_stall"}, 64'(obs_load), 64'(0));
                end
            end
            sc_w_data  = pack_row(b_mat[k]);
            sc_w_valid = 1'b1;
            guard = 0;
            do begin
                tick();
                guard++;
            end while (!obs_w_hs && guard < 20);
            check({name, ":w_handshake"}, 64'(obs_w_hs), 64'(1));
        end
        sc_w_valid = 1'b0;
        sc_w_data  = '0;
    endtask

    task automatic feed_row(input int r, input string name);
        int guard;
        sc_a_data  = pack_row(a_mat[r]);
        sc_a_valid = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!obs_a_hs && guard < 20);
        check({name, ":a_handshake"}, 64'(obs_a_hs), 64'(1));
        sc_a_valid = 1'b0;
        sc_a_data  = '0;
    endtask

    task automatic run_job(input int n, input int w_gap, input int a_gap,
                           input bit start_again, input string name);
        int nr, d0, r0, l0, guard;
        nr = (n == 0) ? 1 : n;
        d0 = done_cnt;
        r0 = res_cnt;
        l0 = load_cnt;
        start_job(n);
        check({name, ":busy_after_start"}, 64'(sc_busy), 64'(1));
        load_weights(w_gap, name);
        for (int r = 0; r < nr; r++) begin
            if (r > 0) begin
                for (int g = 0; g < a_gap; g++) begin
                    sc_a_valid = 1'b0;
                    if (start_again && g == 0) begin
                        sc_start  = 1'b1;
                        sc_n_rows = CNT_W'(5);
                    end
                    tick();
                    sc_start = 1'b0;
                end
            end
            feed_row(r, name);
        end
        guard = 0;
        while (done_cnt == d0 && guard < 40) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 3; i++) tick();
        check({name, ":done_pulses"}, 64'(done_cnt - d0), 64'(1));
        check({name, ":res_rows"},    64'(res_cnt - r0),  64'(nr));
        check({name, ":load_cycles"}, 64'(load_cnt - l0), 64'(DIM));
        check({name, ":sb_empty"},    64'(sb.size()),     64'(0));
        check({name, ":done_vs_last_res"},
              64'((done_cyc - last_res_cyc == 0) || (done_cyc - last_res_cyc == 1)), 64'(1));
        check({name, ":idle_after_done"}, 64'(sc_busy), 64'(0));
`ifdef SA_CTRL_PERF_EN
        check({name, ":bubble_cnt"}, 64'(sc_bubble_cnt), 64'(a_gap * (nr - 1)));
`endif
    endtask

    initial begin
        int d0;
        sc_rst_n   = 1'b0;
        sc_start   = 1'b0;
        sc_n_rows  = '0;
        sc_w_data  = '0;
        sc_w_valid = 1'b0;
        sc_a_data  = '0;
        sc_a_valid = 1'b0;
        sc_sa_gd   = '0;
        tick();
        tick();
        check_reset_vals("reset");
        sc_rst_n = 1'b1;
        tick();

        b_mat    = '{'{1, 2}, '{3, 4}};
        a_mat[0] = '{5, 6};
        a_mat[1] = '{7, 8};

        run_job(2, 0, 0, 1'b0, "basic");
        run_job(2, 0, 2, 1'b0, "bubble");
        run_job(2, 3, 0, 1'b0, "w_stall");
        run_job(2, 0, 2, 1'b1, "start_busy");
        run_job(0, 0, 0, 1'b0, "n_rows_zero");

        // Abort a job mid-FEED with an asynchronous reset between clock edges.
        d0 = done_cnt;
        start_job(3);
        load_weights(0, "abort");
        feed_row(0, "abort");
        @(posedge sc_clk);
        #3;
        sc_rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid_feed");
        sb.delete();
        tick();
        tick();
        check("rst_mid_feed:no_done", 64'(done_cnt - d0), 64'(0));
        sc_rst_n = 1'b1;
        tick();
        run_job(2, 0, 0, 1'b0, "after_reset");

        b_mat    = '{'{3, 5}, '{7, 65535}};
        a_mat[0] = '{1, 2};
        a_mat[1] = '{3, 4};
        a_mat[2] = '{100, 200};
        a_mat[3] = '{65535, 2};
        a_mat[4] = '{9, 10};
        run_job(5, 0, 0, 1'b0, "long_job");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_ctrl.md
Name: sa_ctrl

Overview:
Sequencer for the DIM x DIM weight-stationary systolic array. It preloads the B (weight) rows through the array's load path, then streams A rows with per-column skew into the feed inputs. It deskews the array's result outputs into whole C rows with a valid flag. It sits between the matrix buffers (valid/ready sources) and the systolic array instance, and replaces the hand-timed load/feed sequencing used in bench-level bring-up.

Parameters:
DATA_WIDTH, 16, width of every matrix element
DIM, 2, array dimension (rows = columns of PEs)
ARRAY_LAT, 1, cycles from an element on feed input column 0 to the matching result on result output column 0
CNT_W, 8, width of row counters; the max A row count is 2^CNT_W-1

Ports:
sc_clk  in  1  clock, rising edge
sc_rst_n  in  1  asynchronous active-low reset
sc_start  in  1  one-cycle pulse that starts a job; sampled only in IDLE
sc_n_rows  in  CNT_W  number of A rows for the job, sampled with sc_start; 0 is treated as 1
sc_busy  out  1  high in every state except IDLE
sc_done  out  1  one-cycle pulse when the last result row has been emitted
sc_w_data  in  DIM*DATA_WIDTH  one B row; column j at bits [j*DATA_WIDTH +: DATA_WIDTH]
sc_w_valid / sc_w_ready  in / out  1  weight-row handshake
sc_a_data  in  DIM*DATA_WIDTH  one A row, same packing
sc_a_valid / sc_a_ready  in / out  1  activation-row handshake
sc_sa_load  out  1  array weight-load enable
sc_sa_rd  out  DIM*DATA_WIDTH  array weight inputs
sc_sa_bd_pe  out  DIM  array boundary flags: bit 0 = 1, all other bits = 0, held constant
sc_sa_fdi  out  DIM*DATA_WIDTH  skewed array feed inputs
sc_sa_gd  in  DIM*DATA_WIDTH  array result outputs
sc_res_data  out  DIM*DATA_WIDTH  deskewed C row
sc_res_valid  out  1  sc_res_data is valid; there is no backpressure, so the consumer must accept every valid row

Behaviour:
- Reset values: all outputs 0 except sc_sa_bd_pe = 1; state = IDLE; all pipelines cleared. Reset asserted mid-job aborts the job immediately with no sc_done.
- FSM: IDLE -> LOAD -> FEED -> DRAIN -> IDLE.
- IDLE:
  - sc_start latches sc_n_rows into rows_left and moves to LOAD.
  - sc_start in any other state is ignored.
- LOAD:
  - sc_w_ready = 1.
  - sc_sa_load = sc_w_valid; sc_sa_rd = sc_w_data, combinational.
  - Each handshake counts one row. After DIM handshakes, sc_w_ready drops and the FSM moves to FEED.
  - Gaps in sc_w_valid insert no-load cycles; the array holds its weights.
- FEED:
  - sc_a_ready = 1.
  - On a handshake the row enters the skew stage with tag valid = 1 and rows_left decrements.
  - If sc_a_valid = 0, a zero row with tag valid = 0 (a bubble) enters instead.
  - The handshake that takes rows_left to 0 moves the FSM to DRAIN.
- Skew: column j of each row reaches sc_sa_fdi j cycles after column 0; column 0 is registered once.
- Valid tag: travels in a shift register of length DIM-1+ARRAY_LAT+DIM.
- Deskew: sc_sa_gd column j is delayed by DIM-1-j registers, so all columns of C row r emerge in the same cycle.
- sc_res_valid = delayed tag. Bubbles never raise sc_res_valid.
- Latency: a row accepted in cycle t gives sc_res_valid in cycle t+1+(DIM-1)+ARRAY_LAT+(DIM-1). With defaults this is t+4.
- DRAIN:
  - sc_a_ready = 0; zero rows are fed.
  - When the tag shift register is all zero, sc_done pulses for 1 cycle and the FSM returns to IDLE.
  - sc_done is in the same cycle as or the cycle after the last sc_res_valid.
- Arithmetic: none in this block; the data path is pass-through and widths are unchanged.

Optional Feature:
SA_CTRL_PERF_EN:
- Defined: adds output sc_bubble_cnt [CNT_W-1:0], which counts FEED cycles with sc_a_valid = 0.
  - Clears on an accepted sc_start.
  - Saturates at all-ones.
  - Holds its value after sc_done.
- Undefined: the port and counter are absent.

Decomposition:
- Package sa_pkg holds:
  - DATA_WIDTH and DIM defaults
  - state encoding localparams (IDLE=0, LOAD=1, FEED=2, DRAIN=3)
  - row-slice helper function
- One sub-module, sa_skew_line: a parameterized DATA_WIDTH-bit delay line with depth parameter DEPTH (0 = wire). It is instantiated per column for both skew (DEPTH=j) and deskew (DEPTH=DIM-1-j).

Test Plan:
- Basic 2x2 job:
  - Stimulus: B rows {1,2} then {3,4}; A rows {5,6},{7,8}; n_rows=2; sources always valid; a behavioural array model.
  - Response: sc_sa_load high exactly 2 cycles; res rows {23,34} then {31,46} on consecutive cycles; sc_done 1 cycle later.
- Bubble insertion:
  - Stimulus: same data, sc_a_valid low for 2 cycles between the A rows.
  - Response: identical res values, separated by exactly 2 idle cycles; no spurious sc_res_valid; with SA_CTRL_PERF_EN, sc_bubble_cnt = 2.
- Weight stall: sc_w_valid low 3 cycles between B rows -> sc_sa_load is low in those cycles; results are unchanged.
- Start while busy: a second sc_start during FEED is ignored; only one sc_done. sc_n_rows = 0 behaves as 1 row.
- Reset mid-FEED: sc_rst_n low asynchronously -> all outputs return to reset values immediately; no sc_done; a new job afterwards produces correct results.
- Long job: n_rows = 5 with sc_a_valid continuously high -> 5 back-to-back sc_res_valid cycles; latency from accept to result = 4 cycles with defaults.
